alu_commit_stage: RTL and testbench

Execute-to-writeback pipeline stage directly downstream of the combinational `Alu`. Captures each ALU result (`result`, `result2`, `equal`) with its destination tag in a 2-entry skid buffer under a valid/ready handshake. Owns the architectural HI/LO registers, which are updated by multiply and divide at commit. Resolves beq/bne branch outcomes and drives register-file write-back.

---
 rtl/alu_commit_stage.sv | 127 ++++++++++++
 tb/tb_alu_commit_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_commit_stage.sv
// Execute-to-writeback stage: 2-entry skid buffer behind the ALU, HI/LO commit on pop,
// beq/bne resolution and register-file write-back drive.
module alu_commit_stage (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  in_op_i,
  input  logic [31:0] in_result_i,
  input  logic [31:0] in_result2_i,
  input  logic        in_equal_i,
  input  logic [4:0]  in_rd_i,
  input  logic        in_reg_write_i,
  input  logic [1:0]  in_sel_i,
  input  logic [1:0]  in_branch_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [4:0]  out_rd_o,
  output logic        out_we_o,
  output logic [31:0] out_data_o,
  output logic        out_taken_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [3:0] OpMul = 4'd3;
  localparam logic [3:0] OpDiv = 4'd4;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] result;
    logic [31:0] result2;
    logic        equal;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  sel;
    logic [1:0]  branch;
  } entry_t;

  entry_t      h_q, h_d, s_q, s_d, in_entry;
  logic        h_valid_q, h_valid_d, s_valid_q, s_valid_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        accept, pop;

  assign in_entry = '{
    op:        in_op_i,
    result:    in_result_i,
    result2:   in_result2_i,
    equal:     in_equal_i,
    rd:        in_rd_i,
    reg_write: in_reg_write_i,
    sel:       in_sel_i,
    branch:    in_branch_i
  };

  // Ready is purely the registered skid-empty flag, so no path from out_ready_i.
  assign in_ready_o = ~s_valid_q;
  assign accept     = in_valid_i & in_ready_o;
  assign pop        = h_valid_q & out_ready_i;

  always_comb begin
    h_valid_d = h_valid_q;
    s_valid_d = s_valid_q;
    h_d       = h_q;
    s_d       = s_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (flush_i) begin
      h_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      if (pop && (h_q.op == OpMul || h_q.op == OpDiv)) begin
        lo_d = h_q.result;
        hi_d = h_q.result2;
      end
      if (pop && s_valid_q) begin
        h_d       = s_q;
        s_valid_d = 1'b0;
      end else if (accept && (!h_valid_q || pop)) begin
        h_d       = in_entry;
        h_valid_d = 1'b1;
      end else if (accept) begin
        s_d       = in_entry;
        s_valid_d = 1'b1;
      end else if (pop) begin
        h_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      h_q       <= '0;
      s_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      h_valid_q <= h_valid_d;
      s_valid_q <= s_valid_d;
      h_q       <= h_d;
      s_q       <= s_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    out_data_o = h_q.result;
    unique case (h_q.sel)
      2'b01:   out_data_o = hi_q;
      2'b10:   out_data_o = lo_q;
      default: out_data_o = h_q.result;
    endcase
  end

  assign out_valid_o = h_valid_q;
  assign out_rd_o    = h_q.rd;
  assign out_we_o    = h_valid_q & h_q.reg_write & (h_q.rd != 5'd0);
  assign out_taken_o = h_valid_q & (((h_q.branch == 2'b01) & h_q.equal) |
                                    ((h_q.branch == 2'b10) & ~h_q.equal));
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule

// File: tb/tb_alu_commit_stage.sv
// Self-checking bench for alu_commit_stage: table-driven stream plus backpressure, flush and
// asynchronous-reset sequences, with a scoreboard compared on every pop.
module tb_alu_commit_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, in_equal, in_reg_write, flush;
  logic [3:0]  in_op;
  logic [31:0] in_result, in_result2;
  logic [4:0]  in_rd;
  logic [1:0]  in_sel, in_branch;
  logic        out_valid, out_ready, out_we, out_taken;
  logic [4:0]  out_rd;
  logic [31:0] out_data, hi, lo;

  alu_commit_stage dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_op_i        (in_op),
    .in_result_i    (in_result),
    .in_result2_i   (in_result2),
    .in_equal_i     (in_equal),
    .in_rd_i        (in_rd),
    .in_reg_write_i (in_reg_write),
    .in_sel_i       (in_sel),
    .in_branch_i    (in_branch),
    .flush_i        (flush),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_rd_o       (out_rd),
    .out_we_o       (out_we),
    .out_data_o     (out_data),
    .out_taken_o    (out_taken),
    .hi_o           (hi),
    .lo_o           (lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        taken;
  } exp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] res;
    logic [31:0] res2;
    logic        eq;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  sel;
    logic [1:0]  br;
    logic [31:0] e_data;
    logic        e_we;
    logic        e_taken;
  } vec_t;

  exp_t exp_q[$];
  vec_t vec[12];
  vec_t idle;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic vec_t mkv(input logic [3:0] op, input logic [31:0] res,
                               input logic [31:0] res2, input logic eq, input logic [4:0] rd,
                               input logic rw, input logic [1:0] sel, input logic [1:0] br,
                               input logic [31:0] e_data, input logic e_we, input logic e_taken);
    vec_t v;
    v.op = op; v.res = res; v.res2 = res2; v.eq = eq; v.rd = rd; v.rw = rw;
    v.sel = sel; v.br = br; v.e_data = e_data; v.e_we = e_we; v.e_taken = e_taken;
    return v;
  endfunction

  // Called just after a rising edge; the entry is accepted on the next edge if in_ready is 1.
  task automatic drive(input vec_t v, input logic vld);
    exp_t e;
    in_valid = vld; in_op = v.op; in_result = v.res; in_result2 = v.res2; in_equal = v.eq;
    in_rd = v.rd; in_reg_write = v.rw; in_sel = v.sel; in_branch = v.br;
    if (vld && in_ready && !flush) begin
      e.rd = v.rd; e.data = v.e_data; e.we = v.e_we; e.taken = v.e_taken;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: compare the head whenever it is popped.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {27'd0, out_rd}, 32'hffff_ffff);
      end else begin
        e = exp_q.pop_front();
        chk("pop_rd", {27'd0, out_rd}, {27'd0, e.rd});
        chk("pop_data", out_data, e.data);
        chk("pop_we", {31'd0, out_we}, {31'd0, e.we});
        chk("pop_taken", {31'd0, out_taken}, {31'd0, e.taken});
      end
    end
  end

  initial begin
    idle = mkv(4'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 32'd0, 1'b0, 1'b0);
    //           op     result        result2      eq  rd  rw  sel br   data          we taken
    vec[0]  = mkv(4'd0, 32'd17,       32'd0,       0, 5,  1, 0, 0, 32'd17,       1, 0);
    vec[1]  = mkv(4'd3, 32'h0002_0001, 32'h1,      0, 0,  0, 0, 0, 32'h0002_0001, 0, 0);
    vec[2]  = mkv(4'd0, 32'hdead,     32'd0,       0, 8,  1, 1, 0, 32'h1,        1, 0);
    vec[3]  = mkv(4'd0, 32'hbeef,     32'd0,       0, 9,  1, 2, 0, 32'h0002_0001, 1, 0);
    vec[4]  = mkv(4'd1, 32'd0,        32'd0,       1, 0,  0, 0, 1, 32'd0,        0, 1);
    vec[5]  = mkv(4'd1, 32'd0,        32'd0,       1, 0,  0, 0, 2, 32'd0,        0, 0);
    vec[6]  = mkv(4'd1, 32'd0,        32'd0,       0, 0,  0, 0, 2, 32'd0,        0, 1);
    vec[7]  = mkv(4'd0, 32'd42,       32'd0,       0, 0,  1, 0, 0, 32'd42,       0, 0);
    vec[8]  = mkv(4'd4, 32'd7,        32'd3,       0, 3,  1, 0, 0, 32'd7,        1, 0);
    vec[9]  = mkv(4'd0, 32'd1234,     32'd0,       0, 4,  1, 1, 0, 32'd3,        1, 0);
    vec[10] = mkv(4'd0, 32'd99,       32'd0,       1, 10, 1, 3, 3, 32'd99,       1, 0);
    vec[11] = mkv(4'd0, 32'd555,      32'd0,       0, 11, 1, 2, 0, 32'd7,        1, 0);

    flush = 1'b0; out_ready = 1'b0;
    drive(idle, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_we", {31'd0, out_we}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    // Streaming: one entry per cycle, head valid one cycle after each accept.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i > 0) chk("stream_latency_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      drive(vec[i], 1'b1);
    end
    @(posedge clk); #1;
    chk("stream_latency_valid", {31'd0, out_valid}, 32'd1);
    drive(idle, 1'b0);
    wait_drain("stream_drain");
    repeat (2) @(posedge clk); #1;
    chk("stream_empty", {31'd0, out_valid}, 32'd0);
    chk("stream_hi", hi, 32'd3);
    chk("stream_lo", lo, 32'd7);

    // Backpressure: A to head, B to skid, then release.
    out_ready = 1'b0;
    drive(mkv(4'd0, 32'd3, 32'd0, 0, 1, 1, 0, 0, 32'd3, 1, 0), 1'b1);
    @(posedge clk); #1;
    chk("bp_ready_after_a", {31'd0, in_ready}, 32'd1);
    drive(mkv(4'd0, 32'd5, 32'd0, 0, 2, 1, 0, 0, 32'd5, 1, 0), 1'b1);
    @(posedge clk); #1;
    chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
    chk("bp_head_a", out_data, 32'd3);
    drive(idle, 1'b0);
    @(posedge clk); #1;
    chk("bp_ready_held", {31'd0, in_ready}, 32'd0);
    chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
    chk("bp_head_b", out_data, 32'd5);
    wait_drain("bp_drain");
    repeat (2) @(posedge clk); #1;
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush with full buffer and a div head that would otherwise commit.
    out_ready = 1'b0;
    drive(mkv(4'd4, 32'd2, 32'd5, 0, 6, 1, 0, 0, 32'd2, 1, 0), 1'b1);
    @(posedge clk); #1;
    drive(mkv(4'd0, 32'd11, 32'd0, 0, 7, 1, 0, 0, 32'd11, 1, 0), 1'b1);
    @(posedge clk); #1;
    chk("fl_full", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; out_ready = 1'b1;
    exp_q.delete();
    drive(mkv(4'd0, 32'd77, 32'd0, 0, 9, 1, 0, 0, 32'd77, 1, 0), 1'b1);
    @(posedge clk); #1;
    flush = 1'b0;
    drive(idle, 1'b0);
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    chk("fl_hi", hi, 32'd3);
    chk("fl_lo", lo, 32'd7);
    repeat (2) @(posedge clk); #1;
    chk("fl_still_empty", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-cycle with both entries full.
    out_ready = 1'b0;
    drive(mkv(4'd3, 32'h11, 32'h22, 0, 7, 1, 0, 1, 32'h11, 1, 0), 1'b1);
    @(posedge clk); #1;
    drive(mkv(4'd0, 32'h33, 32'd0, 0, 8, 1, 0, 0, 32'h33, 1, 0), 1'b1);
    @(posedge clk); #1;
    drive(idle, 1'b0);
    chk("ar_pre_we", {31'd0, out_we}, 32'd1);
    chk("ar_pre_full", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
    chk("ar_out_we", {31'd0, out_we}, 32'd0);
    chk("ar_out_taken", {31'd0, out_taken}, 32'd0);
    chk("ar_out_rd", {27'd0, out_rd}, 32'd0);
    chk("ar_out_data", out_data, 32'd0);
    chk("ar_hi", hi, 32'd0);
    chk("ar_lo", lo, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
